xup_2_to_1_arb_reg: RTL and testbench

//  Upstream controller and output stage for the 2:1 vector mux datapath. Arbitrates two

---
 rtl/xup_2_to_1_arb_reg_pkg.sv | 31 +++
 rtl/xup_2_to_1_mux_vector.sv | 33 +++
 rtl/xup_2_to_1_arb_reg.sv | 165 ++++++++++++++++
 tb/tb_xup_2_to_1_arb_reg.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xup_2_to_1_arb_reg_pkg.sv
// ----------------------------------------------------------------------------
// xup_2_to_1_arb_reg_pkg
//   Shared definitions for the 2:1 arbitrated register stage and its vector mux.
//   - GRANT_A / GRANT_B : grant encodings, same sense as the mux select
//                         (0 selects A, 1 selects B).
//   - lock_state_t      : packet-lock state, used when XUP_ARB_LOCK_EN is defined.
//   - rr_grant()        : round-robin grant decision for the unlocked case.
// ----------------------------------------------------------------------------
package xup_2_to_1_arb_reg_pkg;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK_A   = 2'd1,
        LOCK_B   = 2'd2
    } lock_state_t;

    // Returns {grant_b, grant_a}. A lone requester always wins; with both
    // requesting, the channel that did not win last time is granted.
    function automatic logic [1:0] rr_grant(input logic av,
                                            input logic bv,
                                            input logic last);
        if (av && bv) begin
            return (last == GRANT_B) ? 2'b01 : 2'b10;
        end
        return {bv, av};
    endfunction

endpackage

// File: rtl/xup_2_to_1_mux_vector.sv
// ----------------------------------------------------------------------------
// xup_2_to_1_mux_vector
//   SIZE-bit wide 2:1 multiplexer.
//   Parameters:
//     SIZE   data width
//     DELAY  simulation-only propagation delay in ns; has no effect on the
//            synthesised logic
//   Ports:
//     a    in   SIZE  input selected when sel = GRANT_A (0)
//     b    in   SIZE  input selected when sel = GRANT_B (1)
//     sel  in   1     select
//     y    out  SIZE  selected word
// ----------------------------------------------------------------------------
module xup_2_to_1_mux_vector
    import xup_2_to_1_arb_reg_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DELAY = 0
)
(
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            sel,
    output logic [SIZE-1:0] y
);

    // DELAY only shapes simulation timing; it is deliberately not used here.
    logic unused_delay;
    assign unused_delay = (DELAY != 0);

    assign y = (sel == GRANT_B) ? b : a;

endmodule

// File: rtl/xup_2_to_1_arb_reg.sv
// ----------------------------------------------------------------------------
// xup_2_to_1_arb_reg
//   Round-robin arbiter for two valid/ready source channels (A, B) feeding a
//   single one-entry registered output stage with a valid/ready handshake.
//   The winning channel drives the select of an xup_2_to_1_mux_vector whose
//   output is captured into y.
//
//   Optional feature (compile-time macro XUP_ARB_LOCK_EN):
//     Adds a_last / b_last. A beat transferred with last=0 locks the arbiter
//     to that channel until its beat with last=1 transfers.
//
//   Parameters:
//     SIZE   data width of a_data, b_data, y
//     DELAY  simulation-only clk-to-q delay in ns; no effect on the
//            synthesised logic
//   Ports:
//     clk      in   1     rising-edge clock
//     reset    in   1     asynchronous, active-high reset
//     a_data   in   SIZE  channel A word
//     a_valid  in   1     channel A word valid
//     a_last   in   1     channel A end of packet (XUP_ARB_LOCK_EN only)
//     a_ready  out  1     channel A word accepted this cycle
//     b_data   in   SIZE  channel B word
//     b_valid  in   1     channel B word valid
//     b_last   in   1     channel B end of packet (XUP_ARB_LOCK_EN only)
//     b_ready  out  1     channel B word accepted this cycle
//     sel      out  1     combinational mux select, 0 = A, 1 = B
//     y        out  SIZE  registered output word
//     y_valid  out  1     y holds an unconsumed word
//     y_ready  in   1     consumer accepts y this cycle
// ----------------------------------------------------------------------------
module xup_2_to_1_arb_reg
    import xup_2_to_1_arb_reg_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DELAY = 1
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] a_data,
    input  logic            a_valid,
`ifdef XUP_ARB_LOCK_EN
    input  logic            a_last,
`endif
    output logic            a_ready,
    input  logic [SIZE-1:0] b_data,
    input  logic            b_valid,
`ifdef XUP_ARB_LOCK_EN
    input  logic            b_last,
`endif
    output logic            b_ready,
    output logic            sel,
    output logic [SIZE-1:0] y,
    output logic            y_valid,
    input  logic            y_ready
);

    // DELAY only shapes simulation timing; it is deliberately not used here.
    logic unused_delay;
    assign unused_delay = (DELAY != 0);

    logic            last_grant;
    logic            sel_q;
    logic            load;
    logic            grant_a;
    logic            grant_b;
    logic            xfer;
    logic [SIZE-1:0] mux_y;

`ifdef XUP_ARB_LOCK_EN
    lock_state_t     lock_state;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
`ifdef XUP_ARB_LOCK_EN
        // A locked owner keeps the grant even while idle, so the other
        // channel cannot slip a beat into the middle of a packet.
        case (lock_state)
            LOCK_A:  grant_a = a_valid;
            LOCK_B:  grant_b = b_valid;
            default: {grant_b, grant_a} = rr_grant(a_valid, b_valid, last_grant);
        endcase
`else
        {grant_b, grant_a} = rr_grant(a_valid, b_valid, last_grant);
`endif
    end

    // With no grant the select keeps pointing at the last granted channel.
    always_comb begin
        if (grant_a) begin
            sel = GRANT_A;
        end else if (grant_b) begin
            sel = GRANT_B;
        end else begin
            sel = sel_q;
        end
    end

    // The output slot can take a word when it is empty or being drained.
    assign load    = !y_valid || y_ready;
    // Readies are masked during reset so nothing looks accepted while the
    // stage is being cleared.
    assign a_ready = load && grant_a && !reset;
    assign b_ready = load && grant_b && !reset;
    // A grant implies the matching valid, so ready alone marks a transfer.
    assign xfer    = a_ready || b_ready;

    // ------------------------------------------------------------------
    // Datapath mux
    // ------------------------------------------------------------------
    xup_2_to_1_mux_vector #(
        .SIZE  (SIZE),
        .DELAY (0)
    ) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (sel),
        .y   (mux_y)
    );

    // ------------------------------------------------------------------
    // Output register, grant history and lock state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y          <= '0;
            y_valid    <= 1'b0;
            last_grant <= GRANT_B;
            sel_q      <= GRANT_B;
`ifdef XUP_ARB_LOCK_EN
            lock_state <= UNLOCKED;
`endif
        end else begin
            if (grant_a || grant_b) begin
                sel_q <= sel;
            end

            if (xfer) begin
                y          <= mux_y;
                y_valid    <= 1'b1;
                last_grant <= sel;
            end else if (y_ready) begin
                y_valid    <= 1'b0;
            end

`ifdef XUP_ARB_LOCK_EN
            if (a_ready) begin
                lock_state <= a_last ? UNLOCKED : LOCK_A;
            end else if (b_ready) begin
                lock_state <= b_last ? UNLOCKED : LOCK_B;
            end
`endif
        end
    end

    a_one_hot_ready: assert property (@(posedge clk) disable iff (reset)
        !(a_ready && b_ready));

endmodule

// File: tb/tb_xup_2_to_1_arb_reg.sv
module tb_xup_2_to_1_arb_reg;

    localparam int SIZE = 8;

`ifdef XUP_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [SIZE-1:0] a_data;
    logic            a_valid;
    logic            a_ready;
    logic [SIZE-1:0] b_data;
    logic            b_valid;
    logic            b_ready;
    logic            sel;
    logic [SIZE-1:0] y;
    logic            y_valid;
    logic            y_ready;
`ifdef XUP_ARB_LOCK_EN
    logic            a_last;
    logic            b_last;
`endif

    int n_checks = 0;
    int n_errors = 0;

    xup_2_to_1_arb_reg #(
        .SIZE  (SIZE),
        .DELAY (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a_data  (a_data),
        .a_valid (a_valid),
`ifdef XUP_ARB_LOCK_EN
        .a_last  (a_last),
`endif
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
`ifdef XUP_ARB_LOCK_EN
        .b_last  (b_last),
`endif
        .b_ready (b_ready),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after new inputs are driven.
    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- 1: reset with both channels valid ----------------
        reset   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h11;
        b_data  = 8'h99;
        y_ready = 1'b1;
`ifdef XUP_ARB_LOCK_EN
        a_last  = 1'b1;
        b_last  = 1'b1;
`endif
        settle();
        check("rst y",       y,       8'h00);
        check("rst y_valid", y_valid, 1'b0);
        check("rst a_ready", a_ready, 1'b0);
        check("rst b_ready", b_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst y",       y,       8'h00);
            check("rst y_valid", y_valid, 1'b0);
            check("rst a_ready", a_ready, 1'b0);
            check("rst b_ready", b_ready, 1'b0);
        end

        // ---------------- 2: A only, back-to-back ----------------
        reset   = 1'b0;
        b_valid = 1'b0;
        settle();
        check("a_only a_ready0", a_ready, 1'b1);
        check("a_only b_ready0", b_ready, 1'b0);
        check("a_only sel0",     sel,     1'b0);
        step();
        check("a_only y0",       y,       8'h11);
        check("a_only y_valid0", y_valid, 1'b1);
        a_data = 8'h22;
        settle();
        check("a_only a_ready1", a_ready, 1'b1);
        check("a_only sel1",     sel,     1'b0);
        step();
        check("a_only y1",       y,       8'h22);
        a_data = 8'h33;
        settle();
        check("a_only a_ready2", a_ready, 1'b1);
        step();
        check("a_only y2",       y,       8'h33);
        check("a_only y_valid2", y_valid, 1'b1);
        a_valid = 1'b0;
        settle();
        check("idle a_ready",    a_ready, 1'b0);
        check("idle sel hold",   sel,     1'b0);
        step();
        check("drain y_valid",   y_valid, 1'b0);
        check("drain y hold",    y,       8'h33);

        // ---------------- 3: both valid, alternating ----------------
        // A single B beat first makes B the last winner, so A leads.
        b_valid = 1'b1;
        b_data  = 8'hBF;
        settle();
        check("b_only b_ready", b_ready, 1'b1);
        check("b_only sel",     sel,     1'b1);
        step();
        check("b_only y",       y,       8'hBF);
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_data  = 8'(8'hA0 + (k + 1) / 2);
            b_data  = 8'(8'hB0 + k / 2);
            settle();
            check("rr sel",     sel,     32'(k % 2));
            check("rr a_ready", a_ready, 32'((k % 2) == 0));
            check("rr b_ready", b_ready, 32'((k % 2) == 1));
            step();
            check("rr y", y, (k % 2 == 0) ? 32'(8'hA0 + k / 2) : 32'(8'hB0 + k / 2));
            check("rr y_valid", y_valid, 1'b1);
        end

        // ---------------- 4: back-pressure ----------------
        a_valid = 1'b1;
        a_data  = 8'h5C;
        b_valid = 1'b0;
        settle();
        check("bp load a_ready", a_ready, 1'b1);
        step();
        check("bp y",        y,       8'h5C);
        y_ready = 1'b0;
        a_data  = 8'h61;
        b_valid = 1'b1;
        b_data  = 8'h62;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp a_ready", a_ready, 1'b0);
            check("bp b_ready", b_ready, 1'b0);
            check("bp sel",     sel,     1'b1);
            step();
            check("bp y stable", y,       8'h5C);
            check("bp y_valid",  y_valid, 1'b1);
        end
        y_ready = 1'b1;
        settle();
        check("bp release b_ready", b_ready, 1'b1);
        check("bp release a_ready", a_ready, 1'b0);
        step();
        check("bp next y",       y,       8'h62);
        check("bp next y_valid", y_valid, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        check("bp drained", y_valid, 1'b0);

        // ---------------- 5: packet lock / per-beat arbitration ----------------
`ifdef XUP_ARB_LOCK_EN
        a_last = 1'b0;
        b_last = 1'b0;
`endif
        // cycle 0
        a_valid = 1'b1; a_data = 8'hC1;
        b_valid = 1'b1; b_data = 8'hD1;
        settle();
        check("lk c0 a_ready", a_ready, 1'b1);
        check("lk c0 b_ready", b_ready, 1'b0);
        step();
        check("lk c0 y", y, 8'hC1);
        // cycle 1
        a_data = 8'hC2;
        settle();
        check("lk c1 a_ready", a_ready, LOCK ? 1'b1 : 1'b0);
        check("lk c1 b_ready", b_ready, LOCK ? 1'b0 : 1'b1);
        step();
        check("lk c1 y", y, LOCK ? 8'hC2 : 8'hD1);
        // cycle 2
        a_data = LOCK ? 8'hC3 : 8'hC2;
        b_data = LOCK ? 8'hD1 : 8'hD2;
`ifdef XUP_ARB_LOCK_EN
        a_last = 1'b1;
`endif
        settle();
        check("lk c2 a_ready", a_ready, 1'b1);
        check("lk c2 b_ready", b_ready, 1'b0);
        step();
        check("lk c2 y", y, LOCK ? 8'hC3 : 8'hC2);
        // cycle 3
        a_valid = LOCK ? 1'b0 : 1'b1;
        a_data  = 8'hC3;
        settle();
        check("lk c3 a_ready", a_ready, 1'b0);
        check("lk c3 b_ready", b_ready, 1'b1);
        step();
        check("lk c3 y", y, LOCK ? 8'hD1 : 8'hD2);
        // cycle 4: B owns the lock (its beat had last=0) but is idle
        a_valid = 1'b1;
        b_valid = 1'b0;
        settle();
        check("lk c4 a_ready", a_ready, LOCK ? 1'b0 : 1'b1);
        step();
        check("lk c4 y_valid", y_valid, LOCK ? 1'b0 : 1'b1);
        // cycle 5: B closes its packet
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'hDF;
`ifdef XUP_ARB_LOCK_EN
        b_last = 1'b1;
`endif
        settle();
        check("lk c5 b_ready", b_ready, 1'b1);
        check("lk c5 a_ready", a_ready, 1'b0);
        step();
        check("lk c5 y",       y,       8'hDF);
        check("lk c5 y_valid", y_valid, 1'b1);

        // ---------------- 6: reset while holding a word, B last granted ----------------
        a_valid = 1'b1; a_data = 8'hE1;
        b_valid = 1'b1; b_data = 8'hE2;
        reset   = 1'b1;
        settle();
        check("mid rst y_valid", y_valid, 1'b0);
        check("mid rst y",       y,       8'h00);
        check("mid rst a_ready", a_ready, 1'b0);
        check("mid rst b_ready", b_ready, 1'b0);
        step();
        check("mid rst held y_valid", y_valid, 1'b0);
        reset = 1'b0;
        settle();
        check("post rst a_ready", a_ready, 1'b1);
        check("post rst b_ready", b_ready, 1'b0);
        check("post rst sel",     sel,     1'b0);
        step();
        check("post rst y",       y,       8'hE1);
        check("post rst y_valid", y_valid, 1'b1);
        settle();
        check("post rst b_ready2", b_ready, 1'b1);
        step();
        check("post rst y2", y, 8'hE2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
